adsr_envelope: RTL and testbench

//  Per-voice ADSR envelope generator. Scales a signed oscillator sample stream by a linear

---
 rtl/adsr_envelope.sv | 161 ++++++++++++++++
 tb/tb_adsr_envelope.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice linear ADSR envelope generator and sample scaler.
// Sits between the oscillator and the voice mixer. The envelope advances only on valid samples.
// The scaled sample is registered, so wave_out_o trails wave_in_i by one cycle.
// Optional build macro ADSR_EXP_RELEASE_EN gives an exponential release tail.
// Without it the release is linear.
module adsr_envelope #(
  parameter int unsigned WAVE_W = 21,
  parameter int unsigned ENV_W  = 16,
  parameter int unsigned RATE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              global_reset_i,
  input  logic              in_valid_i,
  input  logic [WAVE_W-1:0] wave_in_i,
  input  logic              note_start_i,
  input  logic              note_release_i,
  input  logic              note_reset_i,
  input  logic [RATE_W-1:0] attack_step_i,
  input  logic [RATE_W-1:0] decay_step_i,
  input  logic [ENV_W-1:0]  sustain_level_i,
  input  logic [RATE_W-1:0] release_step_i,
  output logic [WAVE_W-1:0] wave_out_o,
  output logic              out_valid_o,
  output logic [ENV_W-1:0]  env_level_o,
  output logic              note_finished_o
);

  // Arithmetic width: wide enough for env +/- any step without wrapping.
  localparam int unsigned SumW = ((ENV_W > RATE_W) ? ENV_W : RATE_W) + 1;
  localparam logic [ENV_W-1:0] EnvMax = '1;

  typedef enum logic [5:0] {
    StIdle    = 6'b000001,
    StAttack  = 6'b000010,
    StDecay   = 6'b000100,
    StSustain = 6'b001000,
    StRelease = 6'b010000,
    StDone    = 6'b100000
  } state_e;

  state_e              state_q, state_d;
  logic [ENV_W-1:0]    env_q, env_d;
  logic [WAVE_W-1:0]   wave_q, wave_d;
  logic                out_valid_q;
  logic                note_finished_q;

  logic [SumW-1:0]     attack_sum;
  logic [SumW-1:0]     decay_floor;
  logic [SumW-1:0]     decay_diff;
  logic [SumW-1:0]     release_diff;
  logic                release_to_zero;
  logic                active;
  logic signed [WAVE_W+ENV_W:0] product;

  assign active = (state_q == StAttack) || (state_q == StDecay) ||
                  (state_q == StSustain) || (state_q == StRelease);

  // Step arithmetic shared by the next-state logic.
  always_comb begin
    attack_sum  = SumW'(env_q) + SumW'(attack_step_i);
    decay_floor = SumW'(sustain_level_i) + SumW'(decay_step_i);
    decay_diff  = SumW'(env_q) - SumW'(decay_step_i);
`ifdef ADSR_EXP_RELEASE_EN
    // Decrement proportional to env, but never below 1 so the tail always ends.
    begin
      logic [ENV_W-1:0] rel_dec;
      rel_dec = env_q >> release_step_i[3:0];
      if (rel_dec == '0) rel_dec = ENV_W'(1);
      release_diff    = SumW'(env_q) - SumW'(rel_dec);
      release_to_zero = (env_q <= rel_dec);
    end
`else
    release_diff    = SumW'(env_q) - SumW'(release_step_i);
    release_to_zero = (release_step_i == '0) || (SumW'(env_q) <= SumW'(release_step_i));
`endif
  end

  // Next state and envelope: resets, then pulses, then per-sample stepping.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (global_reset_i || note_reset_i) begin
      state_d = StIdle;
      env_d   = '0;
    end else if (note_start_i) begin
      // Retrigger keeps the current level to avoid a click.
      state_d = StAttack;
    end else if (note_release_i &&
                 ((state_q == StAttack) || (state_q == StDecay) || (state_q == StSustain))) begin
      state_d = StRelease;
    end else if (in_valid_i) begin
      unique case (state_q)
        StAttack: begin
          if ((attack_step_i == '0) || (attack_sum >= SumW'(EnvMax))) begin
            env_d   = EnvMax;
            state_d = StDecay;
          end else begin
            env_d = ENV_W'(attack_sum);
          end
        end
        StDecay: begin
          if (sustain_level_i == EnvMax) begin
            env_d   = EnvMax;
            state_d = StSustain;
          end else if ((decay_step_i == '0) || (SumW'(env_q) <= decay_floor)) begin
            env_d   = sustain_level_i;
            state_d = StSustain;
          end else begin
            env_d = ENV_W'(decay_diff);
          end
        end
        StSustain: env_d = sustain_level_i;
        StRelease: begin
          if (release_to_zero) begin
            env_d   = '0;
            state_d = StDone;
          end else begin
            env_d = ENV_W'(release_diff);
          end
        end
        StDone:  env_d = '0;
        default: ;
      endcase
    end
  end

  // Scaled sample uses the pre-update envelope; IDLE/DONE force silence.
  always_comb begin
    product = $signed(wave_in_i) * $signed({1'b0, env_q});
    wave_d  = wave_q;
    if (!active) begin
      wave_d = '0;
    end else if (in_valid_i) begin
      wave_d = WAVE_W'(product >>> ENV_W);
    end
  end

  // State, envelope and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      env_q           <= '0;
      wave_q          <= '0;
      out_valid_q     <= 1'b0;
      note_finished_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      env_q           <= env_d;
      wave_q          <= wave_d;
      out_valid_q     <= in_valid_i & active;
      note_finished_q <= (state_d == StDone);
    end
  end

  assign wave_out_o      = wave_q;
  assign out_valid_o     = out_valid_q;
  assign env_level_o     = env_q;
  assign note_finished_o = note_finished_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope (WAVE_W=21, ENV_W=16, RATE_W=16).
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst;
  logic        global_reset, in_valid, note_start, note_release, note_reset;
  logic [20:0] wave_in;
  logic [15:0] attack_step, decay_step, sustain_level, release_step;
  logic [20:0] wave_out;
  logic        out_valid, note_finished;
  logic [15:0] env_level;

  int checks = 0;
  int errors = 0;

  adsr_envelope #(.WAVE_W(21), .ENV_W(16), .RATE_W(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .global_reset_i  (global_reset),
    .in_valid_i      (in_valid),
    .wave_in_i       (wave_in),
    .note_start_i    (note_start),
    .note_release_i  (note_release),
    .note_reset_i    (note_reset),
    .attack_step_i   (attack_step),
    .decay_step_i    (decay_step),
    .sustain_level_i (sustain_level),
    .release_step_i  (release_step),
    .wave_out_o      (wave_out),
    .out_valid_o     (out_valid),
    .env_level_o     (env_level),
    .note_finished_o (note_finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; global_reset = 0; in_valid = 0; note_start = 0; note_release = 0;
    note_reset = 0; wave_in = 21'h0FFFFF;
    attack_step = 16'h4000; decay_step = 16'h1000; sustain_level = 16'h8000;
    release_step = 16'h3000;
    #3;
    check("rst_env", env_level, 0);
    check("rst_wave", wave_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fin", note_finished, 0);
    tick(); tick();
    rst = 1'b0;

    // Attack ramp, output lags env by one sample.
    note_start = 1; tick(); note_start = 0;
    check("start_env0", env_level, 0);
    in_valid = 1;
    tick(); check("att1_env", env_level, 16'h4000); check("att1_wave", wave_out, 0);
    check("att1_valid", out_valid, 1);
    tick(); check("att2_env", env_level, 16'h8000); check("att2_wave", wave_out, 21'h03FFFF);
    tick(); check("att3_env", env_level, 16'hC000); check("att3_wave", wave_out, 21'h07FFFF);
    tick(); check("att4_env", env_level, 16'hFFFF); check("att4_wave", wave_out, 21'h0BFFFF);
    // Decay down to the sustain floor.
    tick(); check("dec1_env", env_level, 16'hEFFF); check("dec1_wave", wave_out, 21'h0FFFEF);
    repeat (7) tick();
    check("dec_floor", env_level, 16'h8000);
    tick(); check("sus_hold", env_level, 16'h8000);
    check("sus_fin", note_finished, 0);
    sustain_level = 16'h6000; tick(); check("sus_live", env_level, 16'h6000);
    sustain_level = 16'h8000; tick(); check("sus_back", env_level, 16'h8000);

    // Start and release together: start wins, attack resumes from 0x8000.
    in_valid = 0; note_start = 1; note_release = 1; tick(); note_start = 0; note_release = 0;
    check("retrig_hold", env_level, 16'h8000);
    in_valid = 1;
    tick(); check("retrig_att", env_level, 16'hC000);
    tick(); check("retrig_max", env_level, 16'hFFFF);
    repeat (8) tick();
    check("redecay_floor", env_level, 16'h8000);

    // Linear release to DONE.
    in_valid = 0; note_release = 1; tick(); note_release = 0;
    check("rel_hold", env_level, 16'h8000);
    in_valid = 1;
    tick(); check("rel1_env", env_level, 16'h5000); check("rel1_wave", wave_out, 21'h07FFFF);
    tick(); check("rel2_env", env_level, 16'h2000);
    tick(); check("rel3_env", env_level, 16'h0000); check("rel3_fin", note_finished, 1);
    check("rel3_wave", wave_out, 21'h01FFFF); check("rel3_valid", out_valid, 1);
    tick(); check("done_valid", out_valid, 0); check("done_wave", wave_out, 0);
    check("done_fin", note_finished, 1);
    note_reset = 1; tick(); note_reset = 0;
    check("nreset_fin", note_finished, 0); check("nreset_env", env_level, 0);
    tick(); check("idle_valid", out_valid, 0);
    note_release = 1; tick(); note_release = 0;
    tick(); check("idle_rel_ign", env_level, 0); check("idle_rel_valid", out_valid, 0);

    // global_reset beats note_start.
    note_start = 1; tick(); note_start = 0;
    tick(); check("att_again", env_level, 16'h4000);
    global_reset = 1; note_start = 1; tick(); global_reset = 0; note_start = 0;
    check("greset_env", env_level, 0);
    tick(); check("greset_idle", env_level, 0); check("greset_valid", out_valid, 0);

    // Freeze with in_valid low, then async reset without an edge.
    note_start = 1; tick(); note_start = 0;
    tick(); tick(); check("frz_pre", env_level, 16'h8000);
    in_valid = 0;
    repeat (10) tick();
    check("frz_env", env_level, 16'h8000); check("frz_wave", wave_out, 21'h03FFFF);
    check("frz_valid", out_valid, 0);
    #2 rst = 1'b1; #1;
    check("arst_env", env_level, 0); check("arst_wave", wave_out, 0);
    check("arst_fin", note_finished, 0);
    tick(); rst = 1'b0;

    // Zero steps jump straight to their targets.
    attack_step = 0; decay_step = 0; release_step = 0;
    note_start = 1; tick(); note_start = 0;
    in_valid = 1;
    tick(); check("att0_env", env_level, 16'hFFFF);
    tick(); check("dec0_env", env_level, 16'h8000);
    in_valid = 0; note_release = 1; tick(); note_release = 0;
    in_valid = 1;
    tick(); check("rel0_env", env_level, 0); check("rel0_fin", note_finished, 1);
    note_reset = 1; tick(); note_reset = 0;

    // Negative samples floor toward -inf.
    attack_step = 16'h4000; wave_in = 21'h1FFFFF;
    in_valid = 0; note_start = 1; tick(); note_start = 0;
    in_valid = 1;
    tick(); tick(); check("neg1_wave", wave_out, 21'h1FFFFF);
    wave_in = 21'h100000;
    tick(); check("negmin_wave", wave_out, 21'h180000);
    global_reset = 1; tick(); global_reset = 0;

    // Release tail from 0x0100.
    wave_in = 21'h0FFFFF; attack_step = 0; decay_step = 0; sustain_level = 16'h0100;
    in_valid = 0; note_start = 1; tick(); note_start = 0;
    in_valid = 1; tick(); tick();
    check("tail_start", env_level, 16'h0100);
`ifdef ADSR_EXP_RELEASE_EN
    release_step = 16'h0004;
`else
    release_step = 16'h0080;
`endif
    in_valid = 0; note_release = 1; tick(); note_release = 0;
    in_valid = 1;
`ifdef ADSR_EXP_RELEASE_EN
    tick(); check("exp1_env", env_level, 16'h00F0);
    tick(); check("exp2_env", env_level, 16'h00E1);
`else
    tick(); check("lin1_env", env_level, 16'h0080);
`endif
    begin
      int n = 0;
      while (!note_finished && n < 2000) begin
        tick();
        n++;
      end
    end
    check("tail_done", note_finished, 1);
    check("tail_env", env_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
